alu_op_sequencer: RTL and testbench

- Control stage directly upstream of the 16-bit ALU slice array.
- Accepts a 4-bit opcode plus shift amount on a Start pulse.
- Drives the ALU's registered, glitch-free control lines for a programmable settle window, then captures the ALU result and flags.
- Holds a C/Z/N status register that feeds carry back into ADC/SBC.

---
 rtl/alu_seq_pkg.sv | 60 ++++++
 rtl/alu_op_decode.sv | 74 +++++++
 rtl/alu_op_sequencer.sv | 157 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU operation sequencer: opcodes, FSM states and the
// bundle of ALU control lines.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_ADC  = 4'd1,
        OP_SUB  = 4'd2,
        OP_SBC  = 4'd3,
        OP_NEG  = 4'd4,
        OP_MOVB = 4'd5,
        OP_AND  = 4'd6,
        OP_OR   = 4'd7,
        OP_XOR  = 4'd8,
        OP_NOT  = 4'd9,
        OP_NAND = 4'd10,
        OP_NOR  = 4'd11,
        OP_LSL  = 4'd12,
        OP_LSR  = 4'd13,
        OP_ASR  = 4'd14,
        OP_LLI  = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2
    } state_e;

    typedef struct packed {
        logic cin;
        logic sub;
        logic zero_a;
        logic fa_out;
        logic and_op;
        logic or_op;
        logic xor_op;
        logic not_op;
        logic nand_op;
        logic nor_op;
        logic sh_out;
        logic sh_l;
        logic sh_r;
        logic sh_b;
        logic sh_sign_in;
        logic sh8;
        logic sh4;
        logic sh2;
        logic sh1;
        logic sign;
        logic lli;
        logic alu_enable;
    } alu_ctrl_t;

    // Only the adder-based opcodes produce a meaningful carry.
    function automatic logic is_arith(op_e op);
        return (op <= OP_MOVB);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: maps an opcode, shift amount, sign bit and
// current carry flag onto the full set of ALU control lines.
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  op_e        op,
    input  logic [3:0] sh_amt,
    input  logic       b_sign,
    input  logic       flag_c,
    output alu_ctrl_t  ctrl
);

    always_comb begin
        ctrl            = '0;
        ctrl.alu_enable = 1'b1;
        case (op)
            OP_ADD:  ctrl.fa_out = 1'b1;
            OP_ADC: begin
                ctrl.fa_out = 1'b1;
                ctrl.cin    = flag_c;
            end
            OP_SUB: begin
                ctrl.fa_out = 1'b1;
                ctrl.sub    = 1'b1;
                ctrl.cin    = 1'b1;
            end
            OP_SBC: begin
                ctrl.fa_out = 1'b1;
                ctrl.sub    = 1'b1;
                ctrl.cin    = flag_c;
            end
            OP_NEG: begin
                ctrl.fa_out = 1'b1;
                ctrl.sub    = 1'b1;
                ctrl.zero_a = 1'b1;
                ctrl.cin    = 1'b1;
            end
            OP_MOVB: begin
                ctrl.fa_out = 1'b1;
                ctrl.zero_a = 1'b1;
            end
            OP_AND:  ctrl.and_op  = 1'b1;
            OP_OR:   ctrl.or_op   = 1'b1;
            OP_XOR:  ctrl.xor_op  = 1'b1;
            OP_NOT:  ctrl.not_op  = 1'b1;
            OP_NAND: ctrl.nand_op = 1'b1;
            OP_NOR:  ctrl.nor_op  = 1'b1;
            OP_LSL: begin
                ctrl.sh_out = 1'b1;
                ctrl.sh_l   = 1'b1;
                {ctrl.sh8, ctrl.sh4, ctrl.sh2, ctrl.sh1} = sh_amt;
            end
            OP_LSR: begin
                ctrl.sh_out = 1'b1;
                ctrl.sh_r   = 1'b1;
                ctrl.sh_b   = 1'b1;
                {ctrl.sh8, ctrl.sh4, ctrl.sh2, ctrl.sh1} = sh_amt;
            end
            OP_ASR: begin
                ctrl.sh_out     = 1'b1;
                ctrl.sh_r       = 1'b1;
                ctrl.sh_b       = 1'b1;
                ctrl.sh_sign_in = b_sign;
                {ctrl.sh8, ctrl.sh4, ctrl.sh2, ctrl.sh1} = sh_amt;
            end
            OP_LLI: begin
                ctrl.sh_out = 1'b1;
                ctrl.lli    = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequencer in front of the ALU slice array: registers decoded controls for a
// settle window, captures the result and maintains the C/Z/N status register.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int WIDTH         = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       Op,
    input  logic [3:0]       ShAmt,
    input  logic             BSign,
    output logic             Busy,
    output logic             Done,
    output logic             CIn,
    output logic             SUB,
    output logic             ZeroA,
    output logic             FAOut,
    output logic             AND,
    output logic             OR,
    output logic             XOR,
    output logic             NOT,
    output logic             NAND,
    output logic             NOR,
    output logic             ShOut,
    output logic             ShL,
    output logic             ShR,
    output logic             ShB,
    output logic             ShSignIn,
    output logic             Sh1,
    output logic             Sh2,
    output logic             Sh4,
    output logic             Sh8,
    output logic             Sign,
    output logic             LLI,
    output logic             ALUEnable,
    input  logic [WIDTH-1:0] ALUOut,
    input  logic             COut,
    input  logic             nZ,
    input  logic             Sum,
    output logic [WIDTH-1:0] Result,
    output logic             FlagC,
    output logic             FlagZ,
    output logic             FlagN,
    output logic [1:0]       dbg_state
);

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q;
    op_e              op_q;
    alu_ctrl_t        ctrl_q, ctrl_d;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] result_q;
    logic             flag_c_q, flag_z_q, flag_n_q;
    logic             accept, capture;

    alu_op_decode u_decode (
        .op     (op_e'(Op)),
        .sh_amt (ShAmt),
        .b_sign (BSign),
        .flag_c (flag_c_q),
        .ctrl   (ctrl_d)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: if (Start) begin
                state_d = EXEC;
                accept  = 1'b1;
            end
            EXEC: if (cnt_q == 4'd0) state_d = CAPT;
            CAPT: begin
                state_d = IDLE;
                capture = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Controls only move on the accept and capture edges so the ALU sees
    // glitch-free lines for the whole settle window.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_q    <= '0;
            op_q     <= OP_ADD;
            ctrl_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else begin
            done_q <= capture;
            if (accept) begin
                ctrl_q <= ctrl_d;
                op_q   <= op_e'(Op);
                cnt_q  <= CNT_LOAD;
                busy_q <= 1'b1;
            end else if (state_q == EXEC && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (capture) begin
                ctrl_q   <= '0;
                busy_q   <= 1'b0;
                result_q <= ALUOut;
                flag_z_q <= ~nZ;
                flag_n_q <= Sum;
                if (is_arith(op_q)) flag_c_q <= COut;
            end
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Result    = result_q;
    assign FlagC     = flag_c_q;
    assign FlagZ     = flag_z_q;
    assign FlagN     = flag_n_q;
    assign dbg_state = state_q;

    assign CIn       = ctrl_q.cin;
    assign SUB       = ctrl_q.sub;
    assign ZeroA     = ctrl_q.zero_a;
    assign FAOut     = ctrl_q.fa_out;
    assign AND       = ctrl_q.and_op;
    assign OR        = ctrl_q.or_op;
    assign XOR       = ctrl_q.xor_op;
    assign NOT       = ctrl_q.not_op;
    assign NAND      = ctrl_q.nand_op;
    assign NOR       = ctrl_q.nor_op;
    assign ShOut     = ctrl_q.sh_out;
    assign ShL       = ctrl_q.sh_l;
    assign ShR       = ctrl_q.sh_r;
    assign ShB       = ctrl_q.sh_b;
    assign ShSignIn  = ctrl_q.sh_sign_in;
    assign Sh1       = ctrl_q.sh1;
    assign Sh2       = ctrl_q.sh2;
    assign Sh4       = ctrl_q.sh4;
    assign Sh8       = ctrl_q.sh8;
    assign Sign      = ctrl_q.sign;
    assign LLI       = ctrl_q.lli;
    assign ALUEnable = ctrl_q.alu_enable;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU model closing the
// loop from control lines to ALUOut/COut/nZ/Sum.
module tb_alu_op_sequencer;

    // Control vector bit positions, MSB first.
    localparam logic [21:0] K_CIN  = 22'(1) << 21;
    localparam logic [21:0] K_SUB  = 22'(1) << 20;
    localparam logic [21:0] K_ZA   = 22'(1) << 19;
    localparam logic [21:0] K_FA   = 22'(1) << 18;
    localparam logic [21:0] K_AND  = 22'(1) << 17;
    localparam logic [21:0] K_SHO  = 22'(1) << 11;
    localparam logic [21:0] K_SHL  = 22'(1) << 10;
    localparam logic [21:0] K_SHR  = 22'(1) << 9;
    localparam logic [21:0] K_SHB  = 22'(1) << 8;
    localparam logic [21:0] K_SSI  = 22'(1) << 7;
    localparam logic [21:0] K_SH8  = 22'(1) << 6;
    localparam logic [21:0] K_SH4  = 22'(1) << 5;
    localparam logic [21:0] K_SH2  = 22'(1) << 4;
    localparam logic [21:0] K_SH1  = 22'(1) << 3;
    localparam logic [21:0] K_EN   = 22'(1) << 0;

    // ---------------- clock / reset ----------------
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    logic        Start = 1'b0, start4 = 1'b0;
    logic [3:0]  Op = '0, ShAmt = '0;
    logic        BSign = 1'b0;
    logic [15:0] a_opnd = '0, b_opnd = '0;

    logic Busy, Done, CIn, SUB, ZeroA, FAOut, AND, OR, XOR, NOT, NAND, NOR;
    logic ShOut, ShL, ShR, ShB, ShSignIn, Sh1, Sh2, Sh4, Sh8, Sign, LLI, ALUEnable;
    logic [15:0] ALUOut, Result;
    logic COut, nZ, Sum, FlagC, FlagZ, FlagN;
    logic [1:0] dbg_state;
    logic [21:0] ctl;

    assign ctl = {CIn, SUB, ZeroA, FAOut, AND, OR, XOR, NOT, NAND, NOR,
                  ShOut, ShL, ShR, ShB, ShSignIn, Sh8, Sh4, Sh2, Sh1, Sign, LLI, ALUEnable};

    alu_op_sequencer #(.SETTLE_CYCLES(1), .WIDTH(16)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .ShAmt(ShAmt), .BSign(BSign),
        .Busy(Busy), .Done(Done), .CIn(CIn), .SUB(SUB), .ZeroA(ZeroA), .FAOut(FAOut),
        .AND(AND), .OR(OR), .XOR(XOR), .NOT(NOT), .NAND(NAND), .NOR(NOR),
        .ShOut(ShOut), .ShL(ShL), .ShR(ShR), .ShB(ShB), .ShSignIn(ShSignIn),
        .Sh1(Sh1), .Sh2(Sh2), .Sh4(Sh4), .Sh8(Sh8), .Sign(Sign), .LLI(LLI),
        .ALUEnable(ALUEnable), .ALUOut(ALUOut), .COut(COut), .nZ(nZ), .Sum(Sum),
        .Result(Result), .FlagC(FlagC), .FlagZ(FlagZ), .FlagN(FlagN), .dbg_state(dbg_state)
    );

    // Second instance with a longer settle window; its ALU inputs are constant.
    logic busy_4, done_4, cin_4, sub_4, za_4, fa_4, and_4, or_4, xor_4, not_4, nand_4, nor_4;
    logic sho_4, shl_4, shr_4, shb_4, ssi_4, sh1_4, sh2_4, sh4_4, sh8_4, sign_4, lli_4, en_4;
    logic [15:0] result_4;
    logic fc_4, fz_4, fn_4;
    logic [1:0] state_4;
    logic [15:0] aluout_4 = 16'h1234;

    alu_op_sequencer #(.SETTLE_CYCLES(4), .WIDTH(16)) dut4 (
        .Clock(Clock), .Reset(Reset), .Start(start4), .Op(Op), .ShAmt(ShAmt), .BSign(BSign),
        .Busy(busy_4), .Done(done_4), .CIn(cin_4), .SUB(sub_4), .ZeroA(za_4), .FAOut(fa_4),
        .AND(and_4), .OR(or_4), .XOR(xor_4), .NOT(not_4), .NAND(nand_4), .NOR(nor_4),
        .ShOut(sho_4), .ShL(shl_4), .ShR(shr_4), .ShB(shb_4), .ShSignIn(ssi_4),
        .Sh1(sh1_4), .Sh2(sh2_4), .Sh4(sh4_4), .Sh8(sh8_4), .Sign(sign_4), .LLI(lli_4),
        .ALUEnable(en_4), .ALUOut(aluout_4), .COut(1'b0), .nZ(1'b1), .Sum(1'b0),
        .Result(result_4), .FlagC(fc_4), .FlagZ(fz_4), .FlagN(fn_4), .dbg_state(state_4)
    );

    // ---------------- ALU model ----------------
    logic [16:0] m_sum;
    logic [15:0] m_src;
    logic [16:0] m_shr;
    logic [3:0]  m_amt;

    always_comb begin
        ALUOut = '0;
        COut   = 1'b0;
        m_sum  = '0;
        m_src  = ShB ? b_opnd : a_opnd;
        m_amt  = {Sh8, Sh4, Sh2, Sh1};
        m_shr  = 17'($signed({ShSignIn, m_src}) >>> m_amt);
        if (FAOut) begin
            m_sum  = {1'b0, (ZeroA ? 16'h0000 : a_opnd)} + {1'b0, (SUB ? ~b_opnd : b_opnd)} + 17'(CIn);
            ALUOut = m_sum[15:0];
            COut   = m_sum[16];
        end else if (AND)  ALUOut = a_opnd & b_opnd;
        else if (OR)       ALUOut = a_opnd | b_opnd;
        else if (XOR)      ALUOut = a_opnd ^ b_opnd;
        else if (NOT)      ALUOut = ~a_opnd;
        else if (NAND)     ALUOut = ~(a_opnd & b_opnd);
        else if (NOR)      ALUOut = ~(a_opnd | b_opnd);
        else if (ShOut) begin
            if (LLI)      ALUOut = {8'h00, b_opnd[7:0]};
            else if (ShL) ALUOut = m_src << m_amt;
            else if (ShR) ALUOut = m_shr[15:0];
        end
        nZ  = |ALUOut;
        Sum = ALUOut[15];
    end

    // ---------------- checking ----------------
    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] sh, input logic bs,
                          input logic [21:0] ectl, input logic [15:0] eres,
                          input logic ec, input logic ez, input logic en);
        int n;
        @(negedge Clock);
        a_opnd = a; b_opnd = b; Op = op; ShAmt = sh; BSign = bs; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        check({tag, "_busy"}, 32'(Busy), 32'd1);
        check({tag, "_ctl"}, 32'(ctl), 32'(ectl));
        n = 0;
        while (!Done && n < 20) begin
            @(posedge Clock); #1;
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd2);
        check({tag, "_res"}, 32'(Result), 32'(eres));
        check({tag, "_czn"}, 32'({FlagC, FlagZ, FlagN}), 32'({ec, ez, en}));
        check({tag, "_idle"}, 32'({Busy, ctl}), 32'd0);
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (!Done && n < 20) begin
            @(posedge Clock); #1;
            n++;
        end
        if (n >= 20) check({tag, "_timeout"}, 32'(n), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int dones;

        repeat (2) @(posedge Clock);
        #1;
        check("rst_ctl", 32'(ctl), 32'd0);
        check("rst_bd", 32'({Busy, Done}), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_res", 32'({Result, FlagC, FlagZ, FlagN}), 32'd0);
        @(negedge Clock);
        Reset = 1'b0;

        run_op("add",   4'd0,  16'd16328, 16'd9000, 4'd0, 1'b0, K_FA | K_EN, 16'd25328, 1'b0, 1'b0, 1'b0);
        run_op("sbc0",  4'd3,  16'd16328, 16'd9000, 4'd0, 1'b0, K_FA | K_SUB | K_EN, 16'd7327, 1'b1, 1'b0, 1'b0);
        run_op("sub",   4'd2,  16'd16328, 16'd9000, 4'd0, 1'b0, K_CIN | K_FA | K_SUB | K_EN, 16'd7328, 1'b1, 1'b0, 1'b0);
        run_op("sbc1",  4'd3,  16'd16328, 16'd9000, 4'd0, 1'b0, K_CIN | K_FA | K_SUB | K_EN, 16'd7328, 1'b1, 1'b0, 1'b0);
        run_op("neg",   4'd4,  16'd16328, 16'd9000, 4'd0, 1'b0, K_CIN | K_SUB | K_ZA | K_FA | K_EN, 16'd56536, 1'b0, 1'b0, 1'b1);
        run_op("addc",  4'd0,  16'hFFFF, 16'h0001, 4'd0, 1'b0, K_FA | K_EN, 16'h0000, 1'b1, 1'b1, 1'b0);
        run_op("lsl3",  4'd12, 16'd16328, 16'd0, 4'd3, 1'b0, K_SHO | K_SHL | K_SH2 | K_SH1 | K_EN, 16'd65088, 1'b1, 1'b0, 1'b1);
        run_op("and",   4'd6,  16'hF0F0, 16'hFF00, 4'd0, 1'b0, K_AND | K_EN, 16'hF000, 1'b1, 1'b0, 1'b1);
        run_op("asr15", 4'd14, 16'h0000, 16'h8000, 4'd15, 1'b1,
               K_SHO | K_SHR | K_SHB | K_SSI | K_SH8 | K_SH4 | K_SH2 | K_SH1 | K_EN, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        run_op("lsl0",  4'd12, 16'h00AB, 16'h0000, 4'd0, 1'b0, K_SHO | K_SHL | K_EN, 16'h00AB, 1'b1, 1'b0, 1'b0);
        run_op("movb",  4'd5,  16'h1111, 16'h0000, 4'd0, 1'b0, K_FA | K_ZA | K_EN, 16'h0000, 1'b0, 1'b1, 1'b0);
        run_op("addc2", 4'd0,  16'hFFFF, 16'h0001, 4'd0, 1'b0, K_FA | K_EN, 16'h0000, 1'b1, 1'b1, 1'b0);
        run_op("adc",   4'd1,  16'd5, 16'd6, 4'd0, 1'b0, K_CIN | K_FA | K_EN, 16'd12, 1'b0, 1'b0, 1'b0);

        // Start held high through EXEC and CAPT must not restart the operation.
        @(negedge Clock);
        a_opnd = 16'd100; b_opnd = 16'd23; Op = 4'd0; Start = 1'b1;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        check("hold_capt", 32'(dbg_state), 32'd2);
        @(posedge Clock); #1;
        check("hold_done", 32'(Done), 32'd1);
        check("hold_res", 32'(Result), 32'd123);
        Start = 1'b0;
        @(posedge Clock); #1;
        check("hold_idle", 32'({Busy, Done, dbg_state}), 32'd0);

        // Back-to-back: Start raised in the Done cycle.
        @(negedge Clock);
        a_opnd = 16'd7; b_opnd = 16'd8; Op = 4'd0; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        wait_done("b2b_first", n);
        Start = 1'b1;
        Op = 4'd8;
        n = 0;
        @(posedge Clock); #1;
        n++;
        Start = 1'b0;
        check("b2b_busy", 32'(Busy), 32'd1);
        while (!Done && n < 20) begin
            @(posedge Clock); #1;
            n++;
        end
        check("b2b_gap", 32'(n), 32'd3);
        check("b2b_res", 32'(Result), 32'd15);

        // Reset during EXEC aborts without a Done.
        @(negedge Clock);
        a_opnd = 16'hFFFF; b_opnd = 16'h0001; Op = 4'd0; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        check("abort_exec", 32'(dbg_state), 32'd1);
        #2 Reset = 1'b1;
        #1;
        check("abort_zero", 32'({Busy, Done, ctl, dbg_state}), 32'd0);
        check("abort_res", 32'({Result, FlagC, FlagZ, FlagN}), 32'd0);
        @(negedge Clock);
        Reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clock); #1;
            if (Done) dones++;
        end
        check("abort_nodone", 32'(dones), 32'd0);

        // Longer settle window.
        @(negedge Clock);
        start4 = 1'b1;
        @(posedge Clock); #1;
        start4 = 1'b0;
        check("s4_busy", 32'(busy_4), 32'd1);
        n = 0;
        while (!done_4 && n < 20) begin
            @(posedge Clock); #1;
            n++;
        end
        check("s4_lat", 32'(n), 32'd5);
        check("s4_res", 32'(result_4), 32'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
